// File: rtl/imem_pkg.sv
// Shared IMEM definitions: geometry, loader state encoding and the write-port payload.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 64;
  localparam int unsigned IMEM_ADDR_W = $clog2(IMEM_DEPTH);
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    FINISH
  } imem_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

  // Word index to word-aligned byte address.
  function automatic logic [WORD_W-1:0] word_to_addr(input logic [WORD_W-1:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake feeding the IMEM loader (host/boot link side is the master).
interface imem_loader_if;

  logic [imem_pkg::BYTE_W-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/imem_word_packer.sv
// Assembles four accepted stream bytes into one little-endian 32-bit word.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready_c
);

  logic [1:0] byte_idx;

  // High on the handshake that delivers the final byte of a word.
  assign word_ready_c = accept && (byte_idx == 2'd3);

  // Shift in from the top so byte 0 lands in [7:0] after four bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clr) begin
      byte_idx <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      word     <= {data, word[WORD_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// IMEM writer: loads n_words little-endian words from a byte stream to addresses 0,4,8,...
// Optional trailer-byte checksum check when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_words,
  imem_loader_if.slave      strm,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic              chk_err
`endif
);

  imem_state_e      state;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] word_idx;
  logic             in_ready_q;
  logic             accept;
  logic             clr;
  logic             word_ready_c;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q;
`endif

  assign strm.in_ready = in_ready_q;
  assign accept        = strm.in_valid && in_ready_q && (state == LOAD);
  assign clr           = start && (state == IDLE);

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .accept       (accept),
    .data         (strm.in_data),
    .word         (wr_data),
    .word_ready_c (word_ready_c)
  );

  // Load sequencer; every output is set on entry to the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready_q   <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      n_q          <= '0;
      word_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      chk_err      <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q          <= n_words;
            word_idx     <= '0;
            err_overflow <= (n_words > CNT_W'(DEPTH));
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            chk_err      <= 1'b0;
`endif
            if (n_words > CNT_W'(DEPTH)) begin
              state <= FINISH;
              done  <= 1'b1;
            end else if (n_words == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state      <= CHECK;
              in_ready_q <= 1'b1;
              busy       <= 1'b1;
`else
              state <= FINISH;
              done  <= 1'b1;
`endif
            end else begin
              state      <= LOAD;
              in_ready_q <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) sum_q <= sum_q + strm.in_data;
`endif
          if (word_ready_c) begin
            state      <= WRITE;
            in_ready_q <= 1'b0;
            wr_en      <= 1'b1;
            wr_addr    <= word_to_addr(WORD_W'(word_idx));
          end
        end
        WRITE: begin
          word_idx <= word_idx + CNT_W'(1);
          if (word_idx + CNT_W'(1) == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= CHECK;
            in_ready_q <= 1'b1;
`else
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end else begin
            state      <= LOAD;
            in_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (strm.in_valid) begin
            chk_err    <= (strm.in_data != sum_q);
            state      <= FINISH;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
